mat_stream_tx: RTL

MAT_STREAM_TX -- requirements
Module: mat_stream_tx

---
 rtl/mat_stream_tx_pkg.sv | 22 ++
 rtl/mat_stream_tx_word_buf.sv | 36 +++
 rtl/mat_stream_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mat_stream_tx_pkg.sv
// Shared types and helpers for the matrix-frame stream transmitter.
package mat_stream_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSendX,
      StSendW,
      StSendB,
      StFin
   } tx_state_e;

   localparam logic [1:0] SegX    = 2'd0;
   localparam logic [1:0] SegW    = 2'd1;
   localparam logic [1:0] SegB    = 2'd2;
   localparam logic [1:0] SegIdle = 2'd3;

   // Frame length in words: vector, weight matrix, biases.
   function automatic int unsigned frame_len(input int unsigned n, input int unsigned m);
      return n + n * m + m;
   endfunction

endpackage

// File: rtl/mat_stream_tx_word_buf.sv
// Frame word store: one synchronous write port, one combinational read port, no reset.
module tx_word_buf #(
   parameter int unsigned Depth = 11,
   parameter int unsigned AW    = 18
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   localparam int unsigned IW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [31:0]   mem_q [Depth];
   logic [IW-1:0] widx;
   logic [IW-1:0] ridx;

   assign widx = waddr_i[IW-1:0];
   assign ridx = raddr_i[IW-1:0];

   always_ff @(posedge clk_i) begin
      if (we_i && (32'(waddr_i) < Depth)) begin
         mem_q[widx] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = '0;
      if (32'(raddr_i) < Depth) begin
         rdata_o = mem_q[ridx];
      end
   end

endmodule

// File: rtl/mat_stream_tx.sv
// Streams a stored vector/weights/biases frame over a valid/ready link, one word per cycle.
module mat_stream_tx
   import mat_stream_tx_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned M  = 2,
   parameter int unsigned AW = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          start,
   input  logic          abort,
   output logic [31:0]   data_out,
   output logic          data_valid,
   input  logic          data_ready,
   output logic          busy,
   output logic          done,
   output logic [1:0]    seg
);

   localparam int unsigned   L        = frame_len(N, M);
   localparam logic [AW-1:0] LastAddr = AW'(L - 1);

   function automatic logic [1:0] seg_of(input logic [AW-1:0] a);
      if (32'(a) < N) return SegX;
      if (32'(a) < N + N * M) return SegW;
      return SegB;
   endfunction

   function automatic tx_state_e state_of(input logic [1:0] s);
      unique case (s)
         SegX:    return StSendX;
         SegW:    return StSendW;
         default: return StSendB;
      endcase
   endfunction

   tx_state_e     state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [31:0]   data_out_q, data_out_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [1:0]    seg_q, seg_d;

   logic          buf_we;
   logic [AW-1:0] ptr_nxt;
   logic [AW-1:0] rd_addr;
   logic [31:0]   rd_data;
   logic [31:0]   next_word;

   assign buf_we  = wr_en && (state_q == StIdle) && (32'(wr_addr) < L);
   assign ptr_nxt = ptr_q + AW'(1);
   assign rd_addr = (state_q == StIdle) ? '0 : ptr_nxt;
   // Bypass so a write coincident with start is what the first word carries.
   assign next_word = (buf_we && (wr_addr == rd_addr)) ? wr_data : rd_data;

   tx_word_buf #(
      .Depth (L),
      .AW    (AW)
   ) u_buf (
      .clk_i   (clk),
      .we_i    (buf_we),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      data_out_d = data_out_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      seg_d      = seg_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = state_of(seg_of('0));
               ptr_d      = '0;
               data_out_d = next_word;
               valid_d    = 1'b1;
               busy_d     = 1'b1;
               seg_d      = seg_of('0);
            end
         end
         StSendX, StSendW, StSendB: begin
            if (valid_q && data_ready) begin
               if (ptr_q == LastAddr) begin
                  state_d = StFin;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  seg_d   = SegIdle;
               end else begin
                  state_d    = state_of(seg_of(ptr_nxt));
                  ptr_d      = ptr_nxt;
                  data_out_d = next_word;
                  seg_d      = seg_of(ptr_nxt);
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            seg_d   = SegIdle;
         end
      endcase

      // Abort wins over a handshake landing in the same cycle.
      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
         valid_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         seg_d   = SegIdle;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         seg_q      <= SegIdle;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         seg_q      <= seg_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign seg        = seg_q;

endmodule
